sequence_generator_fsm: RTL

SEQUENCE_GENERATOR_FSM -- requirements
Module: sequence_generator_fsm

---
 rtl/sequence_generator_fsm.sv | 112 +++++++++++
 1 files changed

// File: rtl/sequence_generator_fsm.sv
// sequence_generator_fsm: serial pattern transmitter with repeat count, inter-repeat gap and abort
// Ports: clk_i clock; reset_ni sync active-low reset; start_i request; pattern_i/length_i/repeat_i
// transmission setup; abort_i cancel; data_o/valid_o serial stream; busy_o not-idle; done_o completion
// pulse; err_o rejected-start pulse; state_o current state encoding.
module sequence_generator_fsm #(
  parameter int MAX_LEN    = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [3:0]         length_i,
  input  logic [3:0]         repeat_i,
  input  logic               abort_i,
  output logic               data_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2:0]         state_o
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'b000, SEND = 3'b001, GAP = 3'b010, DONE = 3'b011} state_e;
  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q, sh_q, align;
  logic [3:0]         len_q, rep_q, cnt_q;
  logic [GW-1:0]      gap_q;
  logic               len_ok, last;
  // The pattern is left-justified so the first bit to send always sits in the MSB.
  always_comb begin
    len_ok = length_i != 4'd0 && {1'b0, length_i} <= 5'(MAX_LEN);
    align  = pattern_i << (5'(MAX_LEN) - {1'b0, length_i});
    last   = rep_q == 4'd1;
  end
  assign state_o = state_q;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      data_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: if (start_i && !abort_i) begin
          if (len_ok) begin
            state_q <= SEND;
            pat_q   <= align;
            sh_q    <= align << 1;
            len_q   <= length_i;
            rep_q   <= repeat_i;
            cnt_q   <= length_i - 4'd1;
            data_o  <= align[MAX_LEN-1];
            valid_o <= 1'b1;
            busy_o  <= 1'b1;
          end else err_o <= 1'b1;
        end
        SEND, GAP: if (abort_i) begin
          state_q <= IDLE;
          data_o  <= 1'b0;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end else if (state_q == SEND && cnt_q != 4'd0) begin
          data_o <= sh_q[MAX_LEN-1];
          sh_q   <= sh_q << 1;
          cnt_q  <= cnt_q - 4'd1;
        end else if (state_q == SEND && last) begin
          state_q <= DONE;
          data_o  <= 1'b0;
          valid_o <= 1'b0;
          done_o  <= 1'b1;
        end else if (state_q == SEND && GAP_CYCLES != 0) begin
          state_q <= GAP;
          gap_q   <= GW'(GAP_CYCLES - 1);
          data_o  <= 1'b0;
          valid_o <= 1'b0;
          if (rep_q != 4'd0) rep_q <= rep_q - 4'd1;
        end else if (state_q == GAP && gap_q != '0) begin
          gap_q <= gap_q - 1'b1;
        end else begin
          // Restart from the first bit: end of gap, or back-to-back when there is no gap.
          state_q <= SEND;
          data_o  <= pat_q[MAX_LEN-1];
          sh_q    <= pat_q << 1;
          cnt_q   <= len_q - 4'd1;
          valid_o <= 1'b1;
          if (state_q == SEND && rep_q != 4'd0) rep_q <= rep_q - 4'd1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          data_o  <= 1'b0;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule
